state_sequencer: RTL and testbench

- Upstream of the per-state MU configuration stage; produces the 3-bit state_select that stage consumes.
- Accepts asynchronous state-change requests through a one-entry valid/ready buffer. Invalid and redundant requests are rejected or dropped.
- Enforces a minimum dwell time after every change.
- Routes any direct non-NORMAL to non-NORMAL change through NORMAL for a settle interval. The oscillator bank therefore never jumps between two non-NORMAL MU profiles.
- All timing counts clk_en ticks (4 kHz update rate).

---
 rtl/state_sequencer.sv | 120 ++++++++++++
 tb/tb_state_sequencer.sv | 232 +++++++++++++++++++++++
 2 files changed

// File: rtl/state_sequencer.sv
// state_sequencer: buffers state-change requests and commits them to
// state_select for the MU configuration stage. Every committed state is
// held for DWELL_TICKS clk_en ticks, and a change between two non-NORMAL
// states is routed through NORMAL for SETTLE_TICKS ticks first.
module state_sequencer #(
    parameter int DWELL_TICKS  = 4000,
    parameter int SETTLE_TICKS = 400,
    parameter int CNT_W        = 16
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       clk_en,
    input  logic       req_valid,
    input  logic [2:0] req_state,
    output logic       req_ready,
    output logic [2:0] state_select,
    output logic       state_changed,
    output logic       dwell_active,
    output logic       pending_valid,
    output logic [2:0] pending_state,
    output logic       reject_pulse
);

    typedef enum logic [1:0] {
        STABLE = 2'd0,
        SETTLE = 2'd1,
        DWELL  = 2'd2
    } fsm_t;

    localparam logic [2:0]       NORMAL      = 3'd0;
    localparam logic [2:0]       STATE_MAX   = 3'd4;
    localparam logic [CNT_W-1:0] DWELL_LAST  = CNT_W'(DWELL_TICKS - 1);
    localparam logic [CNT_W-1:0] SETTLE_LAST = CNT_W'(SETTLE_TICKS - 1);

    fsm_t             fsm_reg;
    logic [CNT_W-1:0] cnt_reg;
    logic             accept;

    // A full buffer is never overwritten: new requests stall until it drains.
    assign req_ready = !pending_valid;
    assign accept    = req_valid && req_ready;

    // Request buffer, commit FSM, tick counter and registered status outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            fsm_reg       <= STABLE;
            cnt_reg       <= '0;
            state_select  <= NORMAL;
            state_changed <= 1'b0;
            dwell_active  <= 1'b0;
            pending_valid <= 1'b0;
            pending_state <= NORMAL;
            reject_pulse  <= 1'b0;
        end else begin
            state_changed <= 1'b0;
            reject_pulse  <= 1'b0;

            // Accept is only possible while the buffer is empty, so it never
            // collides with a commit that clears the buffer on the same edge.
            if (accept) begin
                if (req_state > STATE_MAX) begin
                    reject_pulse <= 1'b1;
                end else if (!(req_state == state_select && fsm_reg != SETTLE)) begin
                    pending_valid <= 1'b1;
                    pending_state <= req_state;
                end
            end

            case (fsm_reg)
                STABLE: begin
                    // Commit is not gated by clk_en; the count always starts at 0.
                    cnt_reg <= '0;
                    if (pending_valid) begin
                        state_changed <= 1'b1;
                        dwell_active  <= 1'b1;
                        if (state_select != NORMAL && pending_state != NORMAL) begin
                            // Park in NORMAL first; the target stays buffered.
                            state_select <= NORMAL;
                            fsm_reg      <= SETTLE;
                        end else begin
                            state_select  <= pending_state;
                            pending_valid <= 1'b0;
                            fsm_reg       <= DWELL;
                        end
                    end
                end
                SETTLE: begin
                    if (clk_en) begin
                        if (cnt_reg == SETTLE_LAST) begin
                            state_select  <= pending_state;
                            pending_valid <= 1'b0;
                            state_changed <= 1'b1;
                            fsm_reg       <= DWELL;
                            cnt_reg       <= '0;
                        end else begin
                            cnt_reg <= cnt_reg + 1'b1;
                        end
                    end
                end
                DWELL: begin
                    if (clk_en) begin
                        if (cnt_reg == DWELL_LAST) begin
                            fsm_reg      <= STABLE;
                            dwell_active <= 1'b0;
                            cnt_reg      <= '0;
                        end else begin
                            cnt_reg <= cnt_reg + 1'b1;
                        end
                    end
                end
                default: begin
                    fsm_reg      <= STABLE;
                    dwell_active <= 1'b0;
                    cnt_reg      <= '0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_state_sequencer.sv
// Directed bench for state_sequencer with DWELL_TICKS=8, SETTLE_TICKS=4 and
// clk_en asserted on every 4th clock.
module tb_state_sequencer;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       clk_en = 1'b0;
    logic       req_valid = 1'b0;
    logic [2:0] req_state = 3'd0;
    logic       req_ready;
    logic [2:0] state_select;
    logic       state_changed;
    logic       dwell_active;
    logic       pending_valid;
    logic [2:0] pending_state;
    logic       reject_pulse;

    int total = 0;
    int bad = 0;
    int cyc = 0;
    int changed_cnt = 0;
    int reject_cnt = 0;
    int ticks;
    int ready_low;

    state_sequencer #(
        .DWELL_TICKS (8),
        .SETTLE_TICKS(4),
        .CNT_W       (16)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .clk_en       (clk_en),
        .req_valid    (req_valid),
        .req_state    (req_state),
        .req_ready    (req_ready),
        .state_select (state_select),
        .state_changed(state_changed),
        .dwell_active (dwell_active),
        .pending_valid(pending_valid),
        .pending_state(pending_state),
        .reject_pulse (reject_pulse)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input int got, input int exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
        end else begin
            $display("ok   %s = %0d", tag, got);
        end
    endtask

    // Advance one clock; sample 1ns after the edge and set clk_en for the next edge.
    task automatic step();
        @(posedge clk);
        #1;
        if (state_changed) changed_cnt++;
        if (reject_pulse) reject_cnt++;
        cyc++;
        clk_en = (cyc % 4 == 0);
    endtask

    // Present a request for exactly one edge.
    task automatic send(input logic [2:0] st);
        req_valid = 1'b1;
        req_state = st;
        step();
        req_valid = 1'b0;
    endtask

    // Count clk_en edges while dwell_active is high.
    task automatic wait_dwell(output int n_ticks, output int n_low);
        int n = 0;
        n_ticks = 0;
        n_low = 0;
        while (dwell_active && n < 500) begin
            if (clk_en) n_ticks++;
            if (!req_ready) n_low++;
            step();
            n++;
        end
        if (n >= 500) chk("dwell_timeout", n, 0);
    endtask

    // Count clk_en edges spent in SETTLE (pending held while parked in NORMAL).
    task automatic wait_settle(output int n_ticks, output int n_low);
        int n = 0;
        n_ticks = 0;
        n_low = 0;
        while (pending_valid && n < 500) begin
            if (clk_en) n_ticks++;
            if (!req_ready) n_low++;
            step();
            n++;
        end
        if (n >= 500) chk("settle_timeout", n, 0);
    endtask

    initial begin
        // Reset values
        repeat (3) step();
        chk("rst_state_select", int'(state_select), 0);
        chk("rst_pending_valid", int'(pending_valid), 0);
        chk("rst_pending_state", int'(pending_state), 0);
        chk("rst_dwell_active", int'(dwell_active), 0);
        chk("rst_req_ready", int'(req_ready), 1);
        chk("rst_pulses", int'(state_changed) + int'(reject_pulse), 0);
        rst = 1'b0;
        repeat (2) step();

        // NORMAL -> FLOW: direct commit one edge after accept
        changed_cnt = 0;
        chk("flow_ready_before", int'(req_ready), 1);
        send(3'd3);
        chk("flow_pend_after_accept", int'(pending_valid), 1);
        chk("flow_sel_after_accept", int'(state_select), 0);
        step();
        chk("flow_sel_commit", int'(state_select), 3);
        chk("flow_changed", int'(state_changed), 1);
        chk("flow_pend_cleared", int'(pending_valid), 0);
        chk("flow_dwell_on", int'(dwell_active), 1);
        wait_dwell(ticks, ready_low);
        chk("flow_dwell_ticks", ticks, 8);
        chk("flow_ready_low_cycles", ready_low, 0);
        chk("flow_changed_cnt", changed_cnt, 1);

        // FLOW -> ANESTHESIA routed via NORMAL
        changed_cnt = 0;
        send(3'd1);
        step();
        chk("anes_sel_normal", int'(state_select), 0);
        chk("anes_changed1", int'(state_changed), 1);
        chk("anes_pend_kept", int'(pending_valid), 1);
        chk("anes_ready_low", int'(req_ready), 0);
        wait_settle(ticks, ready_low);
        chk("anes_settle_ticks", ticks, 4);
        chk("anes_sel_target", int'(state_select), 1);
        chk("anes_changed2", int'(state_changed), 1);
        wait_dwell(ticks, ready_low);
        chk("anes_dwell_ticks", ticks, 8);
        chk("anes_changed_cnt", changed_cnt, 2);

        // Back to FLOW (routed), then MEDITATION requested during its dwell
        send(3'd3);
        step();
        wait_settle(ticks, ready_low);
        chk("flow2_sel", int'(state_select), 3);
        repeat (3) step();
        send(3'd4);
        chk("med_buffered", int'(pending_valid), 1);
        chk("med_pend_state", int'(pending_state), 4);
        chk("med_ready_low", int'(req_ready), 0);
        req_valid = 1'b1;
        req_state = 3'd2;
        repeat (4) step();
        req_valid = 1'b0;
        chk("psy_stalled_pend_state", int'(pending_state), 4);
        chk("med_sel_holds", int'(state_select), 3);
        wait_dwell(ticks, ready_low);
        chk("med_sel_after_dwell", int'(state_select), 3);
        step();
        chk("med_sel_normal", int'(state_select), 0);
        wait_settle(ticks, ready_low);
        chk("med_settle_ticks", ticks, 4);
        chk("med_sel_target", int'(state_select), 4);
        wait_dwell(ticks, ready_low);

        // Invalid code and redundant request
        reject_cnt = 0;
        changed_cnt = 0;
        send(3'd6);
        chk("rej_pulse", int'(reject_pulse), 1);
        chk("rej_pend", int'(pending_valid), 0);
        chk("rej_sel", int'(state_select), 4);
        step();
        chk("rej_pulse_end", int'(reject_pulse), 0);
        send(3'd4);
        chk("same_pend", int'(pending_valid), 0);
        step();
        chk("same_changed", int'(state_changed), 0);
        chk("rej_cnt", reject_cnt, 1);
        chk("same_changed_cnt", changed_cnt, 0);

        // MEDITATION -> NORMAL direct, NORMAL -> PSYCHEDELIC direct, PSY -> NORMAL direct
        send(3'd0);
        step();
        chk("norm_sel", int'(state_select), 0);
        chk("norm_pend", int'(pending_valid), 0);
        wait_dwell(ticks, ready_low);
        send(3'd2);
        step();
        chk("psy_sel_direct", int'(state_select), 2);
        chk("psy_no_settle", int'(pending_valid), 0);
        wait_dwell(ticks, ready_low);
        chk("psy_dwell_ticks", ticks, 8);
        send(3'd0);
        step();
        chk("psy0_sel", int'(state_select), 0);
        chk("psy0_dwell_on", int'(dwell_active), 1);
        wait_dwell(ticks, ready_low);
        chk("psy0_dwell_ticks", ticks, 8);

        // Reset asserted during SETTLE with a pending request
        send(3'd3);
        step();
        wait_dwell(ticks, ready_low);
        send(3'd1);
        step();
        repeat (2) step();
        chk("settle_pend_before_rst", int'(pending_valid), 1);
        rst = 1'b1;
        #1;
        chk("arst_sel", int'(state_select), 0);
        chk("arst_pend", int'(pending_valid), 0);
        chk("arst_dwell", int'(dwell_active), 0);
        chk("arst_ready", int'(req_ready), 1);
        repeat (2) step();
        rst = 1'b0;
        changed_cnt = 0;
        repeat (30) step();
        chk("post_rst_changed_cnt", changed_cnt, 0);
        chk("post_rst_sel", int'(state_select), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
